// File: rtl/cpu_datapath.sv
// Execution datapath of the accumulator CPU: PC, IR, accumulator, register file,
// ALU and Z/C flags, driven cycle-by-cycle by the controller's strobes.
module cpu_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              LoadIR,
  input  logic              IncPC,
  input  logic              SelPC,
  input  logic              LoadPC,
  input  logic              LoadReg,
  input  logic              LoadAcc,
  input  logic [1:0]        SelAcc,
  input  logic [3:0]        SelALU,
  input  logic [DATA_W+3:0] InstrIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic [3:0]        Opcode,
  output logic              Z,
  output logic              C,
  output logic [PC_W-1:0]   PCOut,
  output logic [DATA_W-1:0] AccOut
);

  localparam int IR_W   = DATA_W + 4;
  localparam int N_REGS = 2 ** REG_AW;
  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOT  = 4'h5,
    ALU_SHL  = 4'h6,
    ALU_SHR  = 4'h7,
    ALU_INC  = 4'h8,
    ALU_DEC  = 4'h9,
    ALU_ADC  = 4'hA,
    ALU_PASS = 4'hB
  } alu_op_e;

  typedef enum logic [1:0] {
    ACC_ALU  = 2'b00,
    ACC_REG  = 2'b01,
    ACC_IMM  = 2'b10,
    ACC_DATA = 2'b11
  } acc_sel_e;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              z_q, c_q;
  logic [DATA_W-1:0] rf_q [N_REGS];

  logic [REG_AW-1:0] rf_addr;
  logic [DATA_W-1:0] rf_rd;
  logic [DATA_W:0]   a_ext, b_ext, alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;
  logic              flags_we;

  assign rf_addr = ir_q[REG_AW-1:0];
  assign rf_rd   = rf_q[rf_addr];
  assign a_ext   = {1'b0, acc_q};
  assign b_ext   = {1'b0, rf_rd};

  // The ALU is computed one bit wide so bit DATA_W carries carry/borrow/shift-out.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    alu_wide = a_ext;
    case (alu_op_e'(SelALU))
      ALU_ADD:  alu_wide = a_ext + b_ext;
      ALU_SUB:  alu_wide = a_ext - b_ext;
      ALU_AND:  alu_wide = {1'b0, acc_q & rf_rd};
      ALU_OR:   alu_wide = {1'b0, acc_q | rf_rd};
      ALU_XOR:  alu_wide = {1'b0, acc_q ^ rf_rd};
      ALU_NOT:  alu_wide = {1'b0, ~acc_q};
      ALU_SHL:  alu_wide = {acc_q, 1'b0};
      ALU_SHR:  alu_wide = {acc_q[0], 1'b0, acc_q[DATA_W-1:1]};
      ALU_INC:  alu_wide = a_ext + ONE;
      ALU_DEC:  alu_wide = a_ext - ONE;
      ALU_ADC:  alu_wide = a_ext + b_ext + {{DATA_W{1'b0}}, c_q};
      ALU_PASS: alu_wide = b_ext;
      default:  alu_wide = a_ext;
    endcase
  end

  assign alu_res  = alu_wide[DATA_W-1:0];
  assign alu_cout = alu_wide[DATA_W];

  always_comb begin
    acc_d = acc_q;
    case (acc_sel_e'(SelAcc))
      ACC_ALU:  acc_d = alu_res;
      ACC_REG:  acc_d = rf_rd;
      ACC_IMM:  acc_d = ir_q[DATA_W-1:0];
      ACC_DATA: acc_d = DataIn;
      default:  acc_d = acc_q;
    endcase
  end

  // A jump target always comes from the IR/Acc held before this edge.
  always_comb begin
    pc_d = pc_q;
    if (LoadPC)     pc_d = SelPC ? ir_q[PC_W-1:0] : acc_q[PC_W-1:0];
    else if (IncPC) pc_d = pc_q + 1'b1;
  end

  assign flags_we = LoadAcc && (acc_sel_e'(SelAcc) == ACC_ALU);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge
  // values; that is what makes a same-cycle RF read and write behave as a swap.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (LoadIR)  ir_q  <= InstrIn;
      if (LoadAcc) acc_q <= acc_d;
      if (flags_we) begin
        z_q <= (alu_res == '0);
        c_q <= alu_cout;
      end
    end
  end

  // NOTE: the register file is cleared on reset because programs may read a
  // register before writing it; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < N_REGS; i++) rf_q[i] <= '0;
    end else if (LoadReg) begin
      rf_q[rf_addr] <= acc_q;
    end
  end

  assign Opcode = ir_q[IR_W-1:DATA_W];
  assign Z      = z_q;
  assign C      = c_q;
  assign PCOut  = pc_q;
  assign AccOut = acc_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath: each step applies one strobe pattern for
// one clock and compares outputs against hand-computed values.
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        CLB;
  logic        LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]  SelAcc;
  logic [3:0]  SelALU;
  logic [11:0] InstrIn;
  logic [7:0]  DataIn;
  logic [3:0]  Opcode;
  logic        Z, C;
  logic [7:0]  PCOut;
  logic [7:0]  AccOut;

  int n_vec = 0;
  int n_err = 0;

  cpu_datapath #(.DATA_W(8), .PC_W(8), .REG_AW(4)) dut (
    .clk(clk), .CLB(CLB),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU),
    .InstrIn(InstrIn), .DataIn(DataIn),
    .Opcode(Opcode), .Z(Z), .C(C), .PCOut(PCOut), .AccOut(AccOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_strobes();
    LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0;
    LoadReg = 0; LoadAcc = 0; SelAcc = 2'b00; SelALU = 4'h0;
  endtask

  // One clock with the given strobes; returns 1 time unit after the rising edge.
  task automatic cyc(input logic lir, input logic ipc, input logic spc, input logic lpc,
                     input logic lreg, input logic lacc, input logic [1:0] sacc,
                     input logic [3:0] salu, input logic [11:0] instr, input logic [7:0] din);
    LoadIR = lir; IncPC = ipc; SelPC = spc; LoadPC = lpc;
    LoadReg = lreg; LoadAcc = lacc; SelAcc = sacc; SelALU = salu;
    InstrIn = instr; DataIn = din;
    @(posedge clk);
    #1;
    idle_strobes();
  endtask

  task automatic set_acc(input logic [7:0] v);
    cyc(0, 0, 0, 0, 0, 1, 2'b11, 4'h0, InstrIn, v);
  endtask

  task automatic alu(input logic [3:0] op);
    cyc(0, 0, 0, 0, 0, 1, 2'b00, op, InstrIn, DataIn);
  endtask

  task automatic check_acc_flags(input string tag, input logic [7:0] acc,
                                 input logic z, input logic c);
    check({tag, ".acc"}, AccOut, acc);
    check({tag, ".z"}, Z, z);
    check({tag, ".c"}, C, c);
  endtask

  initial begin
    idle_strobes();
    InstrIn = '0; DataIn = '0;
    CLB = 1'b0;
    @(posedge clk); #1;
    check("rst.pc", PCOut, 8'h00);
    check("rst.op", Opcode, 4'h0);
    check_acc_flags("rst", 8'h00, 1'b0, 1'b0);
    CLB = 1'b1;

    // Fetch/decode and PC control.
    cyc(1, 1, 0, 0, 0, 0, 2'b00, 4'h0, 12'h3A5, 8'h00);
    check("fetch.op", Opcode, 4'h3);
    check("fetch.pc", PCOut, 8'h01);
    cyc(1, 0, 1, 1, 0, 0, 2'b00, 4'h0, 12'h0FF, 8'h00);
    check("jmp_old_ir.pc", PCOut, 8'hA5);
    check("jmp_old_ir.op", Opcode, 4'h0);
    cyc(0, 0, 1, 1, 0, 0, 2'b00, 4'h0, 12'h0FF, 8'h00);
    check("jmp_ff.pc", PCOut, 8'hFF);
    cyc(0, 1, 0, 0, 0, 0, 2'b00, 4'h0, 12'h0FF, 8'h00);
    check("pc_wrap", PCOut, 8'h00);
    set_acc(8'h42);
    cyc(0, 1, 0, 1, 0, 0, 2'b00, 4'h0, 12'h0FF, 8'h00);
    check("ldpc_over_inc", PCOut, 8'h42);
    InstrIn = 12'hF00;
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 12'hF00, 8'h00);
    check("ir_hold.op", Opcode, 4'h0);
    check("pc_hold", PCOut, 8'h42);

    // RF[5]=0x34, Acc=0x12, then swap in a single edge.
    cyc(1, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h005, 8'h34);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 12'h005, 8'h00);
    set_acc(8'h12);
    cyc(0, 0, 0, 0, 1, 1, 2'b01, 4'h0, 12'h005, 8'h00);
    check("swap.acc", AccOut, 8'h34);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'h0, 12'h005, 8'h00);
    check("swap.rf5", AccOut, 8'h12);
    check("swap.z_hold", Z, 1'b0);

    // RF[1]=0x10; ADD then ADC.
    cyc(1, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h001, 8'h10);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 12'h001, 8'h00);
    set_acc(8'hF0);
    alu(4'h0); check_acc_flags("add", 8'h00, 1'b1, 1'b1);
    alu(4'hA); check_acc_flags("adc", 8'h11, 1'b0, 1'b0);

    // RF[2]=0x07; SUB borrow and a sweep of the remaining ops with B=0x07.
    cyc(1, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h002, 8'h07);
    cyc(0, 0, 0, 0, 1, 0, 2'b00, 4'h0, 12'h002, 8'h00);
    set_acc(8'h05);
    alu(4'h1); check_acc_flags("sub", 8'hFE, 1'b0, 1'b1);
    alu(4'h7); check_acc_flags("shr", 8'h7F, 1'b0, 1'b0);
    alu(4'h2); check_acc_flags("and", 8'h07, 1'b0, 1'b0);
    alu(4'h4); check_acc_flags("xor", 8'h00, 1'b1, 1'b0);
    alu(4'h5); check_acc_flags("not", 8'hFF, 1'b0, 1'b0);
    alu(4'h6); check_acc_flags("shl", 8'hFE, 1'b0, 1'b1);
    alu(4'h8); check_acc_flags("inc", 8'hFF, 1'b0, 1'b0);
    alu(4'h8); check_acc_flags("inc_wrap", 8'h00, 1'b1, 1'b1);
    alu(4'h9); check_acc_flags("dec_borrow", 8'hFF, 1'b0, 1'b1);
    alu(4'h3); check_acc_flags("or", 8'hFF, 1'b0, 1'b0);
    alu(4'hB); check_acc_flags("passb", 8'h07, 1'b0, 1'b0);
    alu(4'h0); check_acc_flags("add_nc", 8'h0E, 1'b0, 1'b0);
    alu(4'h9); check_acc_flags("dec", 8'h0D, 1'b0, 1'b0);
    alu(4'hC); check_acc_flags("rsvd", 8'h0D, 1'b0, 1'b0);

    // Non-ALU Acc loads must leave flags untouched.
    set_acc(8'hFF);
    alu(4'h8); check_acc_flags("hold_setup", 8'h00, 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 4'h0, 12'h000, 8'h00);
    set_acc(8'hAB);
    cyc(0, 0, 0, 0, 0, 1, 2'b10, 4'h0, 12'h000, 8'h00);
    check_acc_flags("imm_hold", 8'h00, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h000, 8'h55);
    check_acc_flags("din_hold", 8'h55, 1'b1, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 12'h000, 8'h99);
    check_acc_flags("idle_hold", 8'h55, 1'b1, 1'b1);

    // Mid-cycle asynchronous reset with random strobes.
    cyc(1, 0, 0, 1, 0, 0, 2'b00, 4'h0, 12'h9AB, 8'h00);
    check("pre_rst.pc", PCOut, 8'h55);
    check("pre_rst.op", Opcode, 4'h9);
    {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc} = 6'($urandom) | 6'b100001;
    SelAcc = 2'($urandom); SelALU = 4'($urandom);
    InstrIn = 12'($urandom) | 12'h100; DataIn = 8'($urandom) | 8'h01;
    #3;
    CLB = 1'b0;
    #1;
    check("arst.pc", PCOut, 8'h00);
    check("arst.op", Opcode, 4'h0);
    check_acc_flags("arst", 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("arst_edge.op", Opcode, 4'h0);
    check("arst_edge.acc", AccOut, 8'h00);
    @(negedge clk);
    idle_strobes();
    CLB = 1'b1;
    #1;

    // Register file must read zero after reset.
    cyc(1, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h005, 8'hAA);
    check("post_rst.acc", AccOut, 8'hAA);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'h0, 12'h005, 8'h00);
    check("post_rst.rf5", AccOut, 8'h00);
    cyc(1, 0, 0, 0, 0, 1, 2'b11, 4'h0, 12'h001, 8'hAA);
    cyc(0, 0, 0, 0, 0, 1, 2'b01, 4'h0, 12'h001, 8'h00);
    check("post_rst.rf1", AccOut, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Datapath for the accumulator CPU; the execution end of the controller interface.
- Consumes the controller's strobes (LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU).
- Produces Opcode, Z and C back to the controller.
- Holds PC, IR, accumulator, a 16-entry register file, the ALU and the flag registers.
- Fetches from external instruction memory via PCOut/InstrIn.

Parameters:
- DATA_W, 8, accumulator/register/immediate width; IR width is 4+DATA_W.
- PC_W, 8, program counter width; must be <= DATA_W.
- REG_AW, 4, register-file address width (2**REG_AW entries).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- CLB  input  1  asynchronous active-low reset (clear).
- LoadIR  input  1  IR <= InstrIn.
- IncPC  input  1  PC <= PC+1 (lower priority than LoadPC).
- SelPC  input  1  PC load source: 0 = Acc[PC_W-1:0], 1 = IR[PC_W-1:0].
- LoadPC  input  1  PC <= source selected by SelPC.
- LoadReg  input  1  RF[IR[REG_AW-1:0]] <= Acc.
- LoadAcc  input  1  Acc <= source selected by SelAcc.
- SelAcc  input  2  00 ALU result, 01 RF[IR addr], 10 IR immediate IR[DATA_W-1:0], 11 DataIn.
- SelALU  input  4  ALU operation code.
- InstrIn  input  4+DATA_W  instruction word from instruction memory.
- DataIn  input  DATA_W  external data input.
- Opcode  output  4  IR[DATA_W+3:DATA_W], combinational from IR.
- Z  output  1  registered zero flag.
- C  output  1  registered carry flag.
- PCOut  output  PC_W  current PC, addresses instruction memory.
- AccOut  output  DATA_W  current accumulator.

Behaviour:
- Reset (CLB=0, asynchronous, independent of clk): PC, IR, Acc, Z, C and all RF entries = 0.
  - Hence Opcode=0, PCOut=0, AccOut=0.
  - Reset overrides any strobe in the same cycle. Mid-operation reset discards the in-flight update.
- State updates: all on the rising edge of clk. Every strobe has 1-cycle latency; the new value is visible after the edge.
- PC:
  - LoadPC=1: PC <= SelPC ? IR[PC_W-1:0] : Acc[PC_W-1:0].
  - Else IncPC=1: PC <= PC+1, wrapping 2**PC_W-1 -> 0.
  - Else: hold.
- IR: loads on LoadIR, else holds. LoadIR with LoadPC/IncPC in the same cycle uses the old IR for the PC target.
- RF:
  - Read address and write address are both IR[REG_AW-1:0].
  - Read-before-write: SelAcc=01 with LoadAcc and LoadReg in the same cycle gives Acc <= old RF value and RF <= old Acc (swap).
- ALU: operand A = Acc, operand B = RF[IR addr]; result is DATA_W bits; cout is the bit DATA_W carry.
  - 0 ADD: A+B, cout = carry.
  - 1 SUB: A-B, cout = borrow (1 when A<B).
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: cout=0.
  - 6 SHL A: cout = A[msb]. 7 SHR A (logical): cout = A[0].
  - 8 INC A: cout = carry. 9 DEC A: cout = borrow (1 when A=0).
  - A ADC: A+B+C, cout = carry. B PASS B: cout=0.
  - C-F reserved: result = A, cout=0.
- Flags:
  - Z and C update only on LoadAcc=1 with SelAcc=00: Z <= (result==0), C <= cout.
  - Any other Acc load, and any cycle without LoadAcc, leaves the flags unchanged.
  - ADC uses the registered C from before the edge.
- Opcode: reflects the new IR the cycle after LoadIR. The controller samples it no earlier than that.
- No strobe asserted: all state holds.

Test Plan:
- Reset: drive strobes randomly, pulse CLB=0 between edges -> all outputs 0 immediately, RF reads 0 afterward.
- Fetch/decode: PCOut=0, InstrIn=0x3A5, LoadIR+IncPC -> Opcode=3, PCOut=1. Then LoadPC, SelPC=1 -> PCOut=0xA5. IncPC at PC=0xFF -> 0x00.
- Load/store swap: Acc=0x12, RF[5]=0x34, IR addr=5, LoadAcc SelAcc=01 + LoadReg same edge -> Acc=0x34, RF[5]=0x12.
- Arithmetic flags: Acc=0xF0, RF[1]=0x10, ADD -> Acc=0x00, Z=1, C=1. Then ADC with RF[1]=0x10 -> Acc=0x11, Z=0, C=0.
- SUB borrow: Acc=0x05, B=0x07 -> Acc=0xFE, C=1, Z=0. Then SHR -> Acc=0x7F, C=0.
- Flag hold: Z=1, C=1, then LoadAcc SelAcc=10 with IR imm=0x00 -> Acc=0x00, Z and C remain 1. Then SelAcc=11, DataIn=0x55 -> Acc=0x55, flags still unchanged.
